etapa_emision: RTL

- Decode/issue stage directly upstream of banco_de_registros.
- Accepts 32-bit RV32I instruction words over a valid/ready handshake and extracts rs1/rs2/rd.
- Tracks pending register writes in a scoreboard and stalls on RAW/WAW hazards.
- Holds the accepted instruction in an issue register whose addr_rs1/addr_rs2 fields drive the register-file read ports directly.

---
 rtl/etapa_emision_pkg.sv | 54 +++++
 rtl/decodificador_instr.sv | 48 ++++
 rtl/etapa_emision.sv | 108 ++++++++++
 3 files changed

// File: rtl/etapa_emision_pkg.sv
// Shared RV32I decode definitions: opcode constants, format codes and the decoded-instruction payload.
package etapa_emision_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FIELD_W = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    // Register fields are already zeroed when the format does not use them.
    typedef struct packed {
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [FIELD_W-1:0] rs1;
        logic [FIELD_W-1:0] rs2;
        logic [FIELD_W-1:0] rd;
        logic               rs1_used;
        logic               rs2_used;
        logic               we;
        logic               illegal;
        logic [INSTR_W-1:0] imm;
    } dec_t;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_R:                      return FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  return FMT_I;
            OP_STORE:                  return FMT_S;
            OP_BRANCH:                 return FMT_B;
            OP_LUI, OP_AUIPC:          return FMT_U;
            OP_JAL:                    return FMT_J;
            default:                   return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decodificador_instr.sv
// Combinational RV32I decoder: field extraction, format, source-used flags and immediate.
module decodificador_instr
    import etapa_emision_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output dec_t               dec
);

    fmt_e               fmt;
    logic               rd_used;
    logic [INSTR_W-1:0] imm_i;
    logic [INSTR_W-1:0] imm_s;
    logic [INSTR_W-1:0] imm_b;
    logic [INSTR_W-1:0] imm_u;
    logic [INSTR_W-1:0] imm_j;

    assign fmt   = fmt_of(instr[6:0]);
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Illegal opcodes decode as a NOP: no sources, no destination, zero immediate.
    always_comb begin
        dec          = '0;
        rd_used      = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
        dec.opcode   = instr[6:0];
        dec.funct3   = instr[14:12];
        dec.funct7   = instr[31:25];
        dec.illegal  = (fmt == FMT_NONE);
        dec.rs1_used = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
        dec.rs2_used = fmt inside {FMT_R, FMT_S, FMT_B};
        dec.rs1      = dec.rs1_used ? instr[19:15] : '0;
        dec.rs2      = dec.rs2_used ? instr[24:20] : '0;
        dec.rd       = rd_used ? instr[11:7] : '0;
        dec.we       = rd_used && (instr[11:7] != '0);
        case (fmt)
            FMT_I:   dec.imm = imm_i;
            FMT_S:   dec.imm = imm_s;
            FMT_B:   dec.imm = imm_b;
            FMT_U:   dec.imm = imm_u;
            FMT_J:   dec.imm = imm_j;
            default: dec.imm = '0;
        endcase
    end

endmodule

// File: rtl/etapa_emision.sv
// Decode/issue stage: scoreboard of pending writes, RAW/WAW stall and issue register feeding the register file.
// Optional macro WB_BYPASS_EN lets a same-cycle write-back release a stall immediately.
module etapa_emision
    import etapa_emision_pkg::*;
#(
    parameter int unsigned N = 5,
    parameter int unsigned M = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [N-1:0]       addr_rs1,
    output logic [N-1:0]       addr_rs2,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [N-1:0]       issue_rd,
    output logic               issue_we,
    output logic [6:0]         issue_opcode,
    output logic [2:0]         issue_funct3,
    output logic [6:0]         issue_funct7,
    output logic [M-1:0]       issue_imm,
    output logic               issue_illegal,
    input  logic               wb_valid,
    input  logic [N-1:0]       wb_rd
);

    localparam int unsigned NREG = 2 ** N;

    dec_t            dec;
    logic [N-1:0]    rs1;
    logic [N-1:0]    rs2;
    logic [N-1:0]    rd;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [NREG-1:0] busy_eff;
    logic [NREG-1:0] wb_mask;
    logic [NREG-1:0] set_mask;
    logic            hazard;
    logic            accept;

    decodificador_instr u_dec (
        .instr (instr),
        .dec   (dec)
    );

    assign rs1 = N'(dec.rs1);
    assign rs2 = N'(dec.rs2);
    assign rd  = N'(dec.rd);

    assign wb_mask  = wb_valid ? (NREG'(1) << wb_rd) : '0;
    assign set_mask = (accept && dec.we) ? (NREG'(1) << rd) : '0;

`ifdef WB_BYPASS_EN
    assign busy_eff = busy & ~wb_mask;
`else
    assign busy_eff = busy;
`endif

    assign hazard = (dec.rs1_used && busy_eff[rs1]) ||
                    (dec.rs2_used && busy_eff[rs2]) ||
                    (dec.we       && busy_eff[rd]);

    assign instr_ready = (!issue_valid || issue_ready) && !hazard;
    assign accept      = instr_valid && instr_ready;

    // Clear before set so a same-cycle allocate of the written-back register stays busy; x0 never busy.
    assign busy_nxt = ((busy & ~wb_mask) | set_mask) & ~NREG'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Issue register: replaced on accept, emptied on a consume without a replacement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid   <= 1'b0;
            addr_rs1      <= '0;
            addr_rs2      <= '0;
            issue_rd      <= '0;
            issue_we      <= 1'b0;
            issue_opcode  <= '0;
            issue_funct3  <= '0;
            issue_funct7  <= '0;
            issue_imm     <= '0;
            issue_illegal <= 1'b0;
        end else if (accept) begin
            issue_valid   <= 1'b1;
            addr_rs1      <= rs1;
            addr_rs2      <= rs2;
            issue_rd      <= rd;
            issue_we      <= dec.we;
            issue_opcode  <= dec.opcode;
            issue_funct3  <= dec.funct3;
            issue_funct7  <= dec.funct7;
            issue_imm     <= M'($signed(dec.imm));
            issue_illegal <= dec.illegal;
        end else if (issue_valid && issue_ready) begin
            issue_valid   <= 1'b0;
        end
    end

endmodule
